// File: rtl/calculator_seq.sv
// Sequential unsigned calculator: add/sub/mul in one cycle, div/rem via
// a restoring shift-subtract divider, valid/ready on both sides.
module calculator_seq #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_low,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    input  logic [2:0]             opcode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     result,
    output logic [1:0]             status,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   op_count
);

    localparam int IW = $clog2(WIDTH);

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_DBZ = 2'd1;
    localparam logic [1:0] ST_BAD = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV_ITER,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_is_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [IW-1:0]    r_iter;

    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_diff;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_nx;
    logic [WIDTH-1:0]     w_quot_nx;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_sub;
    logic [2*WIDTH-1:0]   w_prod;
    logic                 w_is_add;
    logic                 w_is_sub;
    logic                 w_is_mul;
    logic                 w_is_div;
    logic                 w_go_iter;
    logic [2*WIDTH-1:0]   w_fast_res;
    logic [1:0]           w_fast_st;

    // One restoring step: shift in next dividend bit, subtract if it fits
    assign w_shift   = {r_rem, r_quot[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_div};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_rem_nx  = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quot_nx = {r_quot[WIDTH-2:0], w_ge};

    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_sub  = {1'b0, A} - {1'b0, B};
    assign w_prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    assign w_is_add  = (opcode == 3'd1);
    assign w_is_sub  = (opcode == 3'd2);
    assign w_is_mul  = (opcode == 3'd3);
    assign w_is_div  = (opcode == 3'd4) || (opcode == 3'd5);
    assign w_go_iter = w_is_div && (B != '0);

    always_comb begin
        w_fast_res = '0;
        w_fast_st  = ST_BAD;
        unique case (1'b1)
            w_is_add: begin
                w_fast_res = {{(WIDTH-1){1'b0}}, w_sum};
                w_fast_st  = ST_OK;
            end
            w_is_sub: begin
                w_fast_res = {{(WIDTH-1){1'b0}}, w_sub};
                w_fast_st  = ST_OK;
            end
            w_is_mul: begin
                w_fast_res = w_prod;
                w_fast_st  = ST_OK;
            end
            w_is_div: w_fast_st = ST_DBZ;
            default:  w_fast_st = ST_BAD;
        endcase
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            r_state   <= S_IDLE;
            r_is_rem  <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_iter    <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            status    <= ST_OK;
            op_count  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_go_iter) begin
                            r_state  <= S_DIV_ITER;
                            r_is_rem <= (opcode == 3'd5);
                            r_quot   <= A;
                            r_rem    <= '0;
                            r_div    <= B;
                            r_iter   <= '0;
                        end else begin
                            r_state   <= S_DONE;
                            out_valid <= 1'b1;
                            result    <= w_fast_res;
                            status    <= w_fast_st;
                        end
                    end
                end
                S_DIV_ITER: begin
                    r_quot <= w_quot_nx;
                    r_rem  <= w_rem_nx;
                    r_iter <= r_iter + 1'b1;
                    if (r_iter == IW'(WIDTH-1)) begin
                        r_state   <= S_DONE;
                        out_valid <= 1'b1;
                        status    <= ST_OK;
                        result    <= r_is_rem ? {{WIDTH{1'b0}}, w_rem_nx}
                                              : {{WIDTH{1'b0}}, w_quot_nx};
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calculator_seq.sv
// Scoreboard bench for calculator_seq: directed corner cases, random ops,
// backpressure hold and mid-divide reset.
module tb_calculator_seq;

    logic        clk;
    logic        reset_low;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [1:0]  status;
    logic        busy;
    logic [15:0] op_count;

    calculator_seq #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk),
        .reset_low(reset_low),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(A),
        .B(B),
        .opcode(opcode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .status(status),
        .busy(busy),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [1:0]  st;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_total = 0;
    int          n_bad   = 0;
    logic [15:0] exp_cnt = '0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op);
        exp_t        e;
        logic [32:0] d;
        e.res = '0;
        e.st  = 2'd0;
        e.lat = 1;
        d     = '0;
        case (op)
            3'd1: e.res = {32'b0, a} + {32'b0, b};
            3'd2: begin
                d     = {1'b0, a} - {1'b0, b};
                e.res = {31'b0, d};
            end
            3'd3: e.res = {32'b0, a} * {32'b0, b};
            3'd4, 3'd5: begin
                if (b == 0) begin
                    e.st = 2'd1;
                end else begin
                    e.lat = 33;
                    e.res = (op == 3'd4) ? {32'b0, a / b} : {32'b0, a % b};
                end
            end
            default: e.st = 2'd2;
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input int hold);
        exp_t        e;
        int          lat;
        logic [63:0] held;
        @(negedge clk);
        chk("in_ready_idle", {63'b0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        opcode    = op;
        out_ready = 1'b0;
        sb.push_back(model(a, b, op));
        @(negedge clk);
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
        opcode   = 3'($urandom);
        lat      = 1;
        while (!out_valid && lat < 100) begin
            chk("in_ready_busy", {63'b0, in_ready}, 64'd0);
            @(negedge clk);
            lat++;
        end
        chk("out_valid", {63'b0, out_valid}, 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("latency", 64'(lat), 64'(e.lat));
            chk("result", result, e.res);
            chk("status", {62'b0, status}, {62'b0, e.st});
        end else begin
            chk("sb_empty", 64'd1, 64'd0);
        end
        held = result;
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 0);
            A        = 32'd1;
            B        = 32'd1;
            opcode   = 3'd1;
            @(negedge clk);
            in_valid = 1'b0;
            chk("hold_result", result, held);
            chk("hold_valid", {63'b0, out_valid}, 64'd1);
            chk("hold_count", {48'b0, op_count}, {48'b0, exp_cnt});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt   = exp_cnt + 16'd1;
        chk("post_valid", {63'b0, out_valid}, 64'd0);
        chk("op_count", {48'b0, op_count}, {48'b0, exp_cnt});
        chk("post_result", result, held);
    endtask

    initial begin
        reset_low = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        opcode    = '0;
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        opcode   = 3'd1;
        @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_status", {62'b0, status}, 64'd0);
        chk("rst_count", {48'b0, op_count}, 64'd0);
        in_valid  = 1'b0;
        reset_low = 1'b1;

        run_op(32'hFFFF_FFFF, 32'd1, 3'd1, 0);
        chk("add_carry", result, 64'h1_0000_0000);
        run_op(32'd3, 32'd5, 3'd2, 0);
        chk("sub_borrow", result, 64'h1_FFFF_FFFE);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 0);
        chk("mul_max", result, 64'hFFFF_FFFE_0000_0001);
        run_op(32'd100, 32'd7, 3'd4, 0);
        chk("div_100_7", result, 64'd14);
        run_op(32'd100, 32'd7, 3'd5, 0);
        chk("rem_100_7", result, 64'd2);
        run_op(32'd5, 32'd0, 3'd4, 0);
        chk("dbz_status", {62'b0, status}, 64'd1);
        run_op(32'd9, 32'd9, 3'd7, 0);
        chk("bad_status", {62'b0, status}, 64'd2);
        run_op(32'd0, 32'd0, 3'd0, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 3'd4, 0);
        run_op(32'd6, 32'hFFFF_FFFF, 3'd5, 0);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 3'd3, 10);

        for (int k = 0; k < 24; k++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [2:0]  ro;
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            if (k % 3 == 0) rb = 32'($urandom_range(1, 300));
            ro = 3'($urandom_range(0, 7));
            run_op(ra, rb, ro, (k % 5 == 0) ? 2 : 0);
        end

        @(negedge clk);
        in_valid = 1'b1;
        A        = 32'd100;
        B        = 32'd7;
        opcode   = 3'd4;
        sb.push_back(model(32'd100, 32'd7, 3'd4));
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset_low = 1'b0;
        #1;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_valid", {63'b0, out_valid}, 64'd0);
        chk("abort_count", {48'b0, op_count}, 64'd0);
        chk("abort_result", result, 64'd0);
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
        reset_low = 1'b1;
        run_op(32'd2, 32'd2, 3'd1, 0);
        chk("add_after_rst", result, 64'd4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
